bcd_to_bin_seq: RTL and testbench

//  Sequential packed-BCD to binary converter using reverse double-dabble: shift

---
 rtl/bcd_to_bin_seq.sv | 113 +++++++++++
 tb/tb_bcd_to_bin_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - sequential packed-BCD to binary converter (reverse double-dabble)
module bcd_to_bin_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [BIN_W-1:0]      bin_out
);

    localparam int SW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(SW + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SW-1:0]     d_reg;
    logic [SW-1:0]     b_reg;
    logic [SW-1:0]     d_shift;
    logic [SW-1:0]     d_nxt;
    logic [SW-1:0]     b_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              err_l;
    logic              in_bad;
    logic              accept;
    logic              last;

    assign accept = start && ((state == S_IDLE) || (state == S_DONE));
    assign last   = (state == S_CONV) && (cnt == LAST);
    assign busy   = (state == S_CONV);
    assign done   = (state == S_DONE);

    // Flag any input digit outside 0..9 so the result can be forced to zero
    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                in_bad = 1'b1;
            end
        end
    end

    // One reverse double-dabble step: shift {D,B} right, then fix digits >= 8
    always_comb begin
        d_shift = d_reg >> 1;
        b_nxt   = {d_reg[0], b_reg[SW-1:1]};
        d_nxt   = d_shift;
        for (int i = 0; i < DIGITS; i++) begin
            if (d_shift[4*i+3]) begin
                d_nxt[4*i +: 4] = d_shift[4*i +: 4] - 4'd3;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is only honoured outside CONV
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CONV;
            S_CONV:  if (cnt == LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_CONV : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: capture on accepted start, shift during CONV, publish result entering DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_reg   <= '0;
            b_reg   <= '0;
            cnt     <= '0;
            err_l   <= 1'b0;
            err     <= 1'b0;
            bin_out <= '0;
        end else begin
            if (accept) begin
                d_reg <= bcd_in;
                b_reg <= '0;
                cnt   <= '0;
                err_l <= in_bad;
            end else if (state == S_CONV) begin
                d_reg <= d_nxt;
                b_reg <= b_nxt;
                cnt   <= cnt + CNT_W'(1);
            end
            if (last) begin
                bin_out <= err_l ? '0 : BIN_W'(b_nxt);
                err     <= err_l;
            end
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb/tb_bcd_to_bin_seq.sv - directed self-checking bench for bcd_to_bin_seq
module tb_bcd_to_bin_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bcd_in;
    logic        busy;
    logic        done;
    logic        err;
    logic [13:0] bin_out;

    int n_vec;
    int n_err;

    bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .bin_out (bin_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single conversion from the current negedge; checks busy profile, done at cycle 17 and result.
    task automatic run_conv(input logic [15:0] bcd, input logic [13:0] exp_bin,
                            input logic exp_err, input string name);
        int busy_cnt;
        int done_early;
        busy_cnt   = 0;
        done_early = 0;
        start  = 1'b1;
        bcd_in = bcd;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        bcd_in = 16'hFFFF;
        for (int k = 1; k <= 16; k++) begin
            if (k > 1) @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (done !== 1'b0) done_early++;
        end
        n_vec++;
        if (busy_cnt !== 16 || done_early !== 0) begin
            n_err++;
            $display("FAIL %s busy_profile: busy_cycles=%0d early_done=%0d, required 16 and 0",
                     name, busy_cnt, done_early);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s done_cycle17: done=%b busy=%b, required done=1 busy=0", name, done, busy);
        end
        n_vec++;
        if (bin_out !== exp_bin) begin
            n_err++;
            $display("FAIL %s bin_out: got %0d, required %0d", name, bin_out, exp_bin);
        end
        n_vec++;
        if (err !== exp_err) begin
            n_err++;
            $display("FAIL %s err: got %b, required %b", name, err, exp_err);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start  = 1'b0;
        bcd_in = 16'h0000;
        repeat (2) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || bin_out !== 14'd0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b err=%b bin_out=%0d, required all 0",
                     busy, done, err, bin_out);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_conv(16'h1234, 14'd1234, 1'b0, "basic_1234");
    endtask

    task automatic test_max_zero();
        run_conv(16'h9999, 14'd9999, 1'b0, "max_9999");
        run_conv(16'h0000, 14'd0, 1'b0, "zero_0000");
        run_conv(16'h0090, 14'd90, 1'b0, "digit_0090");
    endtask

    task automatic test_invalid();
        run_conv(16'h12A4, 14'd0, 1'b1, "invalid_12A4");
        run_conv(16'h0042, 14'd42, 1'b0, "after_invalid_0042");
    endtask

    task automatic test_back_to_back();
        int n_done;
        int t1;
        int t2;
        logic [13:0] v1;
        logic [13:0] v2;
        n_done = 0;
        t1 = 0;
        t2 = 0;
        v1 = '0;
        v2 = '0;
        start  = 1'b1;
        bcd_in = 16'h0007;
        @(posedge clk);
        @(negedge clk);
        bcd_in = 16'h0100;
        for (int c = 1; c <= 34; c++) begin
            if (c > 1) @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                if (n_done == 1) begin t1 = c; v1 = bin_out; end
                if (n_done == 2) begin t2 = c; v2 = bin_out; end
            end
            if (c == 34) start = 1'b0;
        end
        n_vec++;
        if (n_done !== 2 || t1 !== 17 || t2 !== 34) begin
            n_err++;
            $display("FAIL b2b_timing: dones=%0d at %0d,%0d, required 2 at 17,34", n_done, t1, t2);
        end
        n_vec++;
        if (v1 !== 14'd7 || v2 !== 14'd100) begin
            n_err++;
            $display("FAIL b2b_values: got %0d,%0d, required 7,100", v1, v2);
        end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle_after: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_ignore_start();
        int n_done;
        int t1;
        logic [13:0] v1;
        n_done = 0;
        t1 = 0;
        v1 = '0;
        start  = 1'b1;
        bcd_in = 16'h0321;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (c > 1) @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                t1 = c;
                v1 = bin_out;
            end
            if (c == 5) begin
                start  = 1'b1;
                bcd_in = 16'h5555;
            end
            if (c == 6) start = 1'b0;
        end
        n_vec++;
        if (n_done !== 1 || t1 !== 17) begin
            n_err++;
            $display("FAIL ignore_start_dones: dones=%0d last at %0d, required 1 at 17", n_done, t1);
        end
        n_vec++;
        if (v1 !== 14'd321 || bin_out !== 14'd321) begin
            n_err++;
            $display("FAIL ignore_start_value: got %0d held %0d, required 321", v1, bin_out);
        end
    endtask

    task automatic test_reset_mid();
        start  = 1'b1;
        bcd_in = 16'h0777;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_pre: busy=%b, required 1", busy);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || bin_out !== 14'd0) begin
            n_err++;
            $display("FAIL reset_mid_async: busy=%b done=%b err=%b bin_out=%0d, required all 0",
                     busy, done, err, bin_out);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || bin_out !== 14'd0) begin
            n_err++;
            $display("FAIL reset_mid_idle: busy=%b done=%b bin_out=%0d, required 0 0 0",
                     busy, done, bin_out);
        end
        run_conv(16'h0500, 14'd500, 1'b0, "after_reset_0500");
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_max_zero();
        test_invalid();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
